// File: rtl/ps2_key_tracker_if.sv
// Bundle of the tracker's data-facing signals: the raw receiver history word
// going in and the decoded key events / held-key levels coming out.
interface ps2_key_tracker_if;
    logic [31:0] keycode_in;
    logic        event_valid;
    logic [7:0]  event_code;
    logic        event_ext;
    logic        event_break;
    logic        key_left;
    logic        key_right;
    logic        key_space;
    logic        key_esc;

    // Producer of keycode words, consumer of events
    modport master (
        output keycode_in,
        input  event_valid, event_code, event_ext, event_break,
        input  key_left, key_right, key_space, key_esc
    );

    // The tracker itself
    modport slave (
        input  keycode_in,
        output event_valid, event_code, event_ext, event_break,
        output key_left, key_right, key_space, key_esc
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 key tracker: brings the receiver's 32-bit history word across into the
// system clock, waits for it to sit still, then decodes make / break / E0
// frames into a one-cycle event plus held-key levels for the game controls.
module ps2_key_tracker #(
    parameter int          STABLE_CYCLES = 4,
    parameter logic [7:0]  CODE_LEFT     = 8'h6B,
    parameter logic [7:0]  CODE_RIGHT    = 8'h74,
    parameter logic [7:0]  CODE_SPACE    = 8'h29,
    parameter logic [7:0]  CODE_ESC      = 8'h76
) (
    input  logic               clk,
    input  logic               rst,
    ps2_key_tracker_if.slave   bus
);
    localparam logic [7:0] PREFIX_BREAK = 8'hF0;
    localparam logic [7:0] PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] CNT_LAST     = 8'(STABLE_CYCLES - 1);

    // Tracked keys, index 0..3 = left, right, space, esc
    localparam int         NUM_KEYS  = 4;
    localparam logic [31:0] KEY_CODES = {CODE_ESC, CODE_SPACE, CODE_RIGHT, CODE_LEFT};
    localparam logic [3:0]  KEY_EXT   = 4'b0011;

    typedef enum logic [1:0] {IDLE, SETTLE, EMIT} state_t;

    state_t      state_reg;
    logic [31:0] sync1_reg;
    logic [31:0] sync2_reg;
    logic [31:0] candidate_reg;
    logic [31:0] last_accepted_reg;
    logic [7:0]  cnt_reg;
    logic        event_valid_reg;
    logic [7:0]  event_code_reg;
    logic        event_ext_reg;
    logic        event_break_reg;
    logic [NUM_KEYS-1:0] key_level;

    // Frame decode of the candidate word
    logic [7:0] b0, b1, b2;
    logic       dec_is_event;
    logic       dec_break;
    logic       dec_ext;
    logic       accept;
    logic       emit;

    // Classify the candidate: bare prefixes carry no key, F0 in b1 marks a release
    always_comb begin
        b0           = candidate_reg[7:0];
        b1           = candidate_reg[15:8];
        b2           = candidate_reg[23:16];
        dec_is_event = (b0 != PREFIX_BREAK) && (b0 != PREFIX_EXT);
        dec_break    = (b1 == PREFIX_BREAK);
        dec_ext      = dec_break ? (b2 == PREFIX_EXT) : (b1 == PREFIX_EXT);
        accept       = (state_reg == SETTLE) && (sync2_reg == candidate_reg) &&
                       (cnt_reg == CNT_LAST);
        emit         = accept && dec_is_event;
    end

    // Synchroniser, debounce window and event registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            sync1_reg         <= '0;
            sync2_reg         <= '0;
            candidate_reg     <= '0;
            last_accepted_reg <= '0;
            cnt_reg           <= '0;
            event_valid_reg   <= 1'b0;
            event_code_reg    <= '0;
            event_ext_reg     <= 1'b0;
            event_break_reg   <= 1'b0;
        end else begin
            sync1_reg <= bus.keycode_in;
            sync2_reg <= sync1_reg;
            case (state_reg)
                IDLE: begin
                    if (sync2_reg != last_accepted_reg) begin
                        candidate_reg <= sync2_reg;
                        cnt_reg       <= '0;
                        state_reg     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (sync2_reg != candidate_reg) begin
                        // Word moved again: restart the stability window
                        candidate_reg <= sync2_reg;
                        cnt_reg       <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        last_accepted_reg <= candidate_reg;
                        if (dec_is_event) begin
                            event_valid_reg <= 1'b1;
                            event_code_reg  <= b0;
                            event_ext_reg   <= dec_ext;
                            event_break_reg <= dec_break;
                            state_reg       <= EMIT;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                EMIT: begin
                    event_valid_reg <= 1'b0;
                    state_reg       <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // One held-level flop per tracked key; only a matching code+ext touches it
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            logic level_reg;
            // Set on make, clear on break of this key
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    level_reg <= 1'b0;
                end else if (emit && (b0 == KEY_CODES[gi*8 +: 8]) &&
                             (dec_ext == KEY_EXT[gi])) begin
                    level_reg <= ~dec_break;
                end
            end
            assign key_level[gi] = level_reg;
        end
    endgenerate

    assign bus.event_valid = event_valid_reg;
    assign bus.event_code  = event_code_reg;
    assign bus.event_ext   = event_ext_reg;
    assign bus.event_break = event_break_reg;
    assign bus.key_left    = key_level[0];
    assign bus.key_right   = key_level[1];
    assign bus.key_space   = key_level[2];
    assign bus.key_esc     = key_level[3];
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: stimulus pushes expected events from a
// frame-level model, a negedge monitor pops and compares each DUT pulse.
module tb_ps2_key_tracker;
    localparam int STABLE = 4;
    localparam int LAT    = STABLE + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ps2_key_tracker_if bus ();

    ps2_key_tracker #(.STABLE_CYCLES(STABLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [3:0] levels;   // {esc, space, right, left}
        int         t;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          n_events = 0;

    // Reference model state
    logic [31:0] m_last;
    logic [3:0]  m_levels;
    logic [7:0]  m_code;
    logic        m_ext, m_brk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [3:0] dut_levels();
        return {bus.key_esc, bus.key_space, bus.key_right, bus.key_left};
    endfunction

    // Monitor: every sampled pulse must match the oldest expected event
    always @(negedge clk) begin
        if (!rst && bus.event_valid) begin
            exp_t e;
            n_events++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event got code %h ext %b brk %b want none",
                         bus.event_code, bus.event_ext, bus.event_break);
            end else begin
                e = sbq.pop_front();
                chk("event_code", {24'h0, bus.event_code}, {24'h0, e.code});
                chk("event_ext", {31'h0, bus.event_ext}, {31'h0, e.ext});
                chk("event_break", {31'h0, bus.event_break}, {31'h0, e.brk});
                chk("key_levels", {28'h0, dut_levels()}, {28'h0, e.levels});
                chk("event_latency", cyc - e.t, LAT);
                $display("event code %h ext %b brk %b levels %b", e.code, e.ext, e.brk, e.levels);
            end
        end
    end

    // Frame-level meaning of a history word, applied to the model
    task automatic model_accept(input logic [31:0] w);
        logic [7:0] b0, b1, b2;
        logic       brk, ext;
        int         idx;
        exp_t       e;
        if (w == m_last) return;
        m_last = w;
        b0 = w[7:0]; b1 = w[15:8]; b2 = w[23:16];
        if (b0 == 8'hF0 || b0 == 8'hE0) return;
        brk = (b1 == 8'hF0);
        ext = brk ? (b2 == 8'hE0) : (b1 == 8'hE0);
        idx = -1;
        if (b0 == 8'h6B && ext)  idx = 0;
        if (b0 == 8'h74 && ext)  idx = 1;
        if (b0 == 8'h29 && !ext) idx = 2;
        if (b0 == 8'h76 && !ext) idx = 3;
        if (idx >= 0) m_levels[idx] = !brk;
        m_code = b0; m_ext = ext; m_brk = brk;
        e.code = b0; e.ext = ext; e.brk = brk; e.levels = m_levels; e.t = cyc;
        sbq.push_back(e);
    endtask

    // After a word has settled: nothing outstanding, held outputs agree
    task automatic settle_checks(input string tag);
        chk({tag, "_pending"}, sbq.size(), 0);
        chk({tag, "_levels"}, {28'h0, dut_levels()}, {28'h0, m_levels});
        chk({tag, "_held"}, {22'h0, bus.event_code, bus.event_ext, bus.event_break},
            {22'h0, m_code, m_ext, m_brk});
        sbq.delete();
    endtask

    // Called at a negedge: drive a word, model it, hold it
    task automatic apply_word(input logic [31:0] w, input int hold, input string tag);
        bus.keycode_in = w;
        model_accept(w);
        repeat (hold) @(negedge clk);
        settle_checks(tag);
    endtask

    task automatic glitch(input logic [31:0] w);
        bus.keycode_in = w;
        repeat (2) @(negedge clk);
    endtask

    logic [31:0] word;
    logic [7:0]  nb;
    int          ev_before;
    logic [7:0]  pool [8] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h29, 8'h76, 8'h12, 8'h1C};

    initial begin
        bus.keycode_in = '0;
        m_last = '0; m_levels = '0; m_code = '0; m_ext = 1'b0; m_brk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("reset_outputs", {19'h0, bus.event_valid, bus.event_code, bus.event_ext,
                              bus.event_break, dut_levels()}, 32'h0);
        chk("reset_no_event", n_events, 0);

        // Space make then break through its F0 prefix
        apply_word(32'h0000_0029, 50, "space_make");
        apply_word(32'h0000_29F0, 50, "space_prefix");
        apply_word(32'h0029_F029, 50, "space_break");

        // Extended left arrow make / break
        apply_word(32'h0000_00E0, 50, "left_e0");
        apply_word(32'h0000_E06B, 50, "left_make");
        apply_word(32'h00E0_6BF0, 50, "left_prefix");
        apply_word(32'hE06B_F06B, 50, "left_break");

        // Esc glitch is swallowed, only space is reported
        ev_before = n_events;
        glitch(32'h0000_0076);
        apply_word(32'h0000_0029, 50, "glitch");
        chk("glitch_event_count", n_events - ev_before, 1);

        // Non-extended 6B is not left arrow
        apply_word(32'h0000_006B, 50, "plain_6b");

        // Reset in the middle of the settle window of the next word
        bus.keycode_in = 32'h0000_0074;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset_outputs", {19'h0, bus.event_valid, bus.event_code, bus.event_ext,
                                 bus.event_break, dut_levels()}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_last = '0; m_levels = '0; m_code = '0; m_ext = 1'b0; m_brk = 1'b0;
        ev_before = n_events;
        apply_word(32'h0000_0074, 50, "after_reset");
        chk("after_reset_event_count", n_events - ev_before, 1);

        // Random receiver-like byte stream with occasional glitches
        word = 32'h0000_0074;
        for (int i = 0; i < 80; i++) begin
            do nb = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
            while (nb == word[7:0]);
            word = {word[23:0], nb};
            if ($urandom_range(0, 4) == 0) glitch($urandom);
            apply_word(word, $urandom_range(20, 40), "random");
        end

        repeat (20) @(negedge clk);
        chk("final_pending", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
